// File: rtl/tri_raster_pkg.sv
// Shared definitions for the triangle rasterizer and its downstream collector.
//   CW_DEF       : default coordinate width (grid is 2^CW_DEF square)
//   N_DEF        : default grid edge length
//   coll_state_e : collector FSM states
//   point_t      : one rasterized point {x, y}
package tri_raster_pkg;

    localparam int CW_DEF = 3;
    localparam int N_DEF  = 1 << CW_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } coll_state_e;

    typedef struct packed {
        logic [CW_DEF-1:0] x;
        logic [CW_DEF-1:0] y;
    } point_t;

endpackage

// File: rtl/tri_bitmap_store.sv
// N x N occupancy bitmap held in flops.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears everything)
//   clr_i             : synchronous clear of the whole bitmap
//   set_en_i/y/x      : set bit [y][x]; prior_o gives that bit's value before the set
//   rd_en_i, rd_y_i   : load row rd_y_i into the registered read port
//   rd_row_o          : registered row data
module tri_bitmap_store
    import tri_raster_pkg::*;
#(
    parameter int  CW = CW_DEF,
    localparam int N  = 1 << CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          set_en_i,
    input  logic [CW-1:0] set_y_i,
    input  logic [CW-1:0] set_x_i,
    output logic          prior_o,
    input  logic          rd_en_i,
    input  logic [CW-1:0] rd_y_i,
    output logic [N-1:0]  rd_row_o
);

    logic [N-1:0] mem_q [N];
    logic [N-1:0] rd_row_q;

    // Combinational look-up lets the caller classify the point as new or
    // duplicate in the same cycle the set is issued.
    assign prior_o  = mem_q[set_y_i][set_x_i];
    assign rd_row_o = rd_row_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (set_en_i) begin
            mem_q[set_y_i][set_x_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_row_q <= '0;
        end else if (rd_en_i) begin
            rd_row_q <= mem_q[rd_y_i];
        end
    end

endmodule

// File: rtl/tri_bitmap_collector.sv
// Collects one triangle's rasterized points into an occupancy bitmap, counts
// unique pixels, flags duplicates and stray points, then streams the bitmap
// out one row per transfer.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   busy_i                : rasterizer frame in progress
//   po_i, xo_i, yo_i      : point strobe and coordinates
//   row_ready             : downstream accepts the presented row
//   row_valid, row_idx,
//   row_bits              : row output (bit x set = pixel (x, row_idx) drawn)
//   pix_count             : unique pixels in the frame
//   frame_done            : one-cycle pulse after the last row is accepted
//   dup_err, lost_err     : sticky duplicate / point-outside-collect flags
//   state_o               : current FSM state (debug)
module tri_bitmap_collector
    import tri_raster_pkg::*;
#(
    parameter int  CW = CW_DEF,
    localparam int N  = 1 << CW,
    localparam int PW = 2 * CW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          busy_i,
    input  logic          po_i,
    input  logic [CW-1:0] xo_i,
    input  logic [CW-1:0] yo_i,
    input  logic          row_ready,
    output logic          row_valid,
    output logic [CW-1:0] row_idx,
    output logic [N-1:0]  row_bits,
    output logic [PW-1:0] pix_count,
    output logic          frame_done,
    output logic          dup_err,
    output logic          lost_err,
    output logic [1:0]    state_o
);

    coll_state_e   state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          dup_q, dup_d;
    logic          lost_q, lost_d;
    logic          row_valid_q, row_valid_d;
    logic [CW-1:0] row_idx_q, row_idx_d;

    logic          set_en;
    logic          prior;
    logic          rd_en;
    logic [CW-1:0] rd_y;
    logic          clr_all;

    tri_bitmap_store #(.CW(CW)) u_store (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (clr_all),
        .set_en_i (set_en),
        .set_y_i  (yo_i),
        .set_x_i  (xo_i),
        .prior_o  (prior),
        .rd_en_i  (rd_en),
        .rd_y_i   (rd_y),
        .rd_row_o (row_bits)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            dup_q       <= 1'b0;
            lost_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            dup_q       <= dup_d;
            lost_q      <= lost_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
        end
    end

    // Row handshake: a transfer happens on a clock edge where row_valid and
    // row_ready are both high. While row_valid is high and row_ready is low,
    // row_valid, row_idx and row_bits hold. The row after a transfer is read
    // from the bitmap on that same edge, so it is presented the next cycle.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        dup_d       = dup_q;
        lost_d      = lost_q;
        row_valid_d = row_valid_q;
        row_idx_d   = row_idx_q;
        set_en      = 1'b0;
        rd_en       = 1'b0;
        rd_y        = '0;
        clr_all     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (busy_i) begin
                    // Frame start; the bitmap is already clear, so a point
                    // arriving with busy is always new.
                    state_d = COLLECT;
                    pix_d   = po_i ? PW'(1) : '0;
                    dup_d   = 1'b0;
                    lost_d  = 1'b0;
                    set_en  = po_i;
                end else if (po_i) begin
                    lost_d = 1'b1;
                end
            end
            COLLECT: begin
                if (po_i) begin
                    set_en = 1'b1;
                    if (prior) begin
                        dup_d = 1'b1;
                    end else if (pix_q != PW'(N * N)) begin
                        pix_d = pix_q + PW'(1);
                    end
                end
                if (!busy_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (po_i) begin
                    lost_d = 1'b1;
                end
                if (!row_valid_q) begin
                    // First DRAIN cycle: prefetch row 0.
                    rd_en       = 1'b1;
                    rd_y        = '0;
                    row_valid_d = 1'b1;
                    row_idx_d   = '0;
                end else if (row_ready) begin
                    if (row_idx_q == CW'(N - 1)) begin
                        row_valid_d = 1'b0;
                        clr_all     = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rd_en     = 1'b1;
                        rd_y      = row_idx_q + CW'(1);
                        row_idx_d = row_idx_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (po_i) begin
                    lost_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign row_valid  = row_valid_q;
    assign row_idx    = row_idx_q;
    assign pix_count  = pix_q;
    assign dup_err    = dup_q;
    assign lost_err   = lost_q;
    assign frame_done = (state_q == DONE);
    assign state_o    = state_q;

endmodule
